// File: rtl/cep_pkg.sv
// Shared types and default widths for the cepstral coefficient memory arbiter.
package cep_pkg;

  localparam int unsigned CEP_DATA_LENGTH = 16;
  localparam int unsigned CEP_ADDR_LENGTH = 13;
  localparam int unsigned CEP_MEM_DEPTH   = 8192;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_W = 2'd1,
    OWN_R = 2'd2
  } cep_state_e;

  // The owner state a handover moves to.
  function automatic cep_state_e cep_other(input cep_state_e s);
    return (s == OWN_W) ? OWN_R : OWN_W;
  endfunction

endpackage

// File: rtl/cep_mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the single-port cepstral memory
// between a write and a read requester. Optional macro CEP_ARB_BOUND_EN adds address bounds checking.
module cep_mem_arbiter
  import cep_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = CEP_DATA_LENGTH,
  parameter int unsigned ADDR_LENGTH = CEP_ADDR_LENGTH,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned MEM_DEPTH   = CEP_MEM_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req,
  input  logic [ADDR_LENGTH-1:0] wr_addr,
  input  logic [DATA_LENGTH-1:0] wr_data,
  output logic                   wr_ack,
  input  logic                   rd_req,
  input  logic [ADDR_LENGTH-1:0] rd_addr,
  output logic                   rd_ack,
  output logic [DATA_LENGTH-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   mem_write_read,
  output logic [ADDR_LENGTH-1:0] mem_address,
  output logic [DATA_LENGTH-1:0] mem_data_in,
`ifdef CEP_ARB_BOUND_EN
  output logic                   addr_err,
`endif
  input  logic [DATA_LENGTH-1:0] mem_data_out
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST) + 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  // Reject configurations that cannot be addressed or never grant.
  if ((64'(MEM_DEPTH) > (64'(1) << ADDR_LENGTH)) || (MAX_BURST == 0)) begin : g_bad_cfg
    $error("cep_mem_arbiter: MEM_DEPTH exceeds address space or MAX_BURST is zero");
  end

  cep_state_e           state_q, state_d;
  logic                 prio_q, prio_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 own_req, oth_req;
  logic                 wr_oob, rd_oob;

`ifdef CEP_ARB_BOUND_EN
  localparam int unsigned CMP_W = ADDR_LENGTH + 1;
  logic addr_err_q, addr_err_d;

  assign wr_oob = (CMP_W'(wr_addr) >= CMP_W'(MEM_DEPTH));
  assign rd_oob = (CMP_W'(rd_addr) >= CMP_W'(MEM_DEPTH));
  assign addr_err_d = (wr_ack && wr_oob) || (rd_ack && rd_oob);
  assign addr_err   = addr_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end
`else
  assign wr_oob = 1'b0;
  assign rd_oob = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      burst_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      burst_q    <= burst_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state: ownership handover, priority and burst accounting.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    burst_d = burst_q;
    own_req = 1'b0;
    oth_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req && rd_req) begin
          state_d = prio_q ? OWN_R : OWN_W;
        end else if (wr_req) begin
          state_d = OWN_W;
        end else if (rd_req) begin
          state_d = OWN_R;
        end
      end
      OWN_W, OWN_R: begin
        own_req = (state_q == OWN_W) ? wr_req : rd_req;
        oth_req = (state_q == OWN_W) ? rd_req : wr_req;
        // own_req is also this cycle's ack, so a full burst needs own_req high.
        if (oth_req && (!own_req || (burst_q == BURST_LAST))) begin
          state_d = cep_other(state_q);
          prio_d  = (state_q == OWN_W);
        end else if (!own_req && !oth_req) begin
          state_d = IDLE;
          prio_d  = (state_q == OWN_W);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      burst_d = '0;
    end else if (own_req && (burst_q != BURST_LAST)) begin
      burst_d = burst_q + BURST_W'(1);
    end
  end

  // Outputs: memory port mux and acks, all combinational from the owner.
  always_comb begin
    wr_ack         = 1'b0;
    rd_ack         = 1'b0;
    mem_write_read = 1'b0;
    mem_address    = '0;
    mem_data_in    = '0;
    rd_valid_d     = 1'b0;
    case (state_q)
      OWN_W: begin
        wr_ack = wr_req;
        if (wr_req && !wr_oob) begin
          mem_write_read = 1'b1;
          mem_address    = wr_addr;
          mem_data_in    = wr_data;
        end
      end
      OWN_R: begin
        rd_ack = rd_req;
        if (rd_req && !rd_oob) begin
          mem_address = rd_addr;
          rd_valid_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? mem_data_out : '0;

endmodule
